// File: rtl/mbank_sram.sv
// NB-bank simple dual-port buffer with per-bank read-valid, optional output register and ping-pong pages.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, every enabled read yields one QV pulse.
module mbank_sram #(
   parameter int NB        = 4,
   parameter int DW        = 64,
   parameter int DEPTH     = 64,
   parameter int AW        = $clog2(DEPTH),
   parameter int OUT_REG   = 0,
   parameter int PING_PONG = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NB-1:0]      WE,
   input  logic [NB*AW-1:0]   WADDR,
   input  logic [NB*DW-1:0]   D,
   input  logic [NB-1:0]      RE,
   input  logic [NB*AW-1:0]   RADDR,
   input  logic               SWAP,
   output logic               PAGE,
   output logic [NB*DW-1:0]   Q,
   output logic [NB-1:0]      QV
);
   localparam int PW     = AW + ((PING_PONG != 0) ? 1 : 0);
   // Page 1 starts at 2**AW so the physical address stays a plain {page, addr} concatenation.
   localparam int MDEPTH = (PING_PONG != 0) ? (1 << AW) + DEPTH : DEPTH;
   localparam bit FULL   = (DEPTH == (1 << AW));

   logic page;

   generate
      if (PING_PONG != 0) begin : g_pp
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)
               page <= 1'b0;
            else if (SWAP)
               page <= ~page;
         end
      end else begin : g_nopp
         logic unused_swap;
         assign unused_swap = SWAP;
         assign page        = 1'b0;
      end
   endgenerate

   assign PAGE = page;

   for (genvar b = 0; b < NB; b++) begin : g_bank
      logic [DW-1:0] mem [MDEPTH];
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      logic [PW-1:0] wpa;
      logic [PW-1:0] rpa;
      logic          w_ok;
      logic          r_ok;
      logic [DW-1:0] rd;
      logic          v1;
      logic [DW-1:0] d1;

      assign wa = WADDR[b*AW +: AW];
      assign ra = RADDR[b*AW +: AW];

      if (PING_PONG != 0) begin : g_pa
         assign wpa = {page, wa};
         assign rpa = {~page, ra};
      end else begin : g_a
         assign wpa = wa;
         assign rpa = ra;
      end

      if (FULL) begin : g_full
         assign w_ok = 1'b1;
         assign r_ok = 1'b1;
      end else begin : g_part
         localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
         assign w_ok = ({1'b0, wa} < DEPTH_V);
         assign r_ok = ({1'b0, ra} < DEPTH_V);
      end

      always_ff @(posedge CLK) begin
         if (WE[b] && w_ok)
            mem[wpa] <= D[b*DW +: DW];
      end

      // Sampled at the same edge as the write, so a colliding read sees the old word.
      assign rd = r_ok ? mem[rpa] : '0;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            v1 <= 1'b0;
            d1 <= '0;
         end else begin
            v1 <= RE[b];
            if (RE[b])
               d1 <= rd;
         end
      end

      if (OUT_REG != 0) begin : g_oreg
         logic          v2;
         logic [DW-1:0] d2;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               v2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               if (v1)
                  d2 <= d1;
            end
         end

         assign Q[b*DW +: DW] = d2;
         assign QV[b]         = v2;
      end else begin : g_noreg
         assign Q[b*DW +: DW] = d1;
         assign QV[b]         = v1;
      end
   end

endmodule
